// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core (ADD/SUB/AND/OR/SRL, LW/SW, BEQ; J when MULTICYCLE_CORE_JUMP_EN is defined).
// Latency: BEQ/J 3 cycles, R-type/SW 4, LW 5, plus one cycle per memory wait state.
// Backpressure: mem_req held with stable addr/we/wdata until mem_ready; TIMEOUT wait cycles halt the core.
module multicycle_core #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              retire,
    output logic              halted,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc4, br_tgt;
    logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [31:0]       alu_q, alu_d, mdr_q, mdr_d, alu_res, pc4_w, br_sum;
    logic [7:0]        wait_q, wait_d;
    logic [1:0]        err_q, err_d;
    logic              run_q, run_d;
    logic [31:0]       rf_q [32];
    logic [31:0]       rf_d [32];
    logic              legal;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd, shamt;
    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];

    assign pc4    = pc_q + ADDR_W'(4);
    assign pc4_w  = 32'(pc4);
    assign br_sum = pc4_w + {imm_q[29:0], 2'b00};
    assign br_tgt = br_sum[ADDR_W-1:0];

`ifdef MULTICYCLE_CORE_JUMP_EN
    logic [31:0]       j_full;
    logic [ADDR_W-1:0] j_tgt;
    assign j_full = {pc4_w[31:28], ir_q[25:0], 2'b00};
    assign j_tgt  = j_full[ADDR_W-1:0];
`endif

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R:                  legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SRL};
            OP_LW, OP_SW, OP_BEQ:  legal = 1'b1;
`ifdef MULTICYCLE_CORE_JUMP_EN
            OP_J:                  legal = 1'b1;
`endif
            default:               legal = 1'b0;
        endcase
    end

    // Non-R opcodes reaching the ALU are LW/SW, which need rs + sext(imm).
    always_comb begin
        alu_res = a_q + imm_q;
        if (opcode == OP_R) begin
            case (funct)
                F_SUB:   alu_res = a_q - b_q;
                F_AND:   alu_res = a_q & b_q;
                F_OR:    alu_res = a_q | b_q;
                F_SRL:   alu_res = b_q >> shamt;
                default: alu_res = a_q + b_q;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        wait_d    = '0;
        err_d     = err_q;
        run_d     = 1'b1;
        rf_d      = rf_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = b_q;
        retire    = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req = run_q;
                if (run_q && mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d   = rf_q[rs];
                b_d   = rf_q[rt];
                imm_d = {{16{ir_q[15]}}, ir_q[15:0]};
                if (legal) begin
                    state_d = EXEC;
                end else begin
                    state_d = HALT;
                    err_d   = 2'b01;
                end
            end
            EXEC: begin
                alu_d = alu_res;
                case (opcode)
                    OP_BEQ: begin
                        retire  = 1'b1;
                        pc_d    = (a_q == b_q) ? br_tgt : pc4;
                        state_d = FETCH;
                    end
`ifdef MULTICYCLE_CORE_JUMP_EN
                    OP_J: begin
                        retire  = 1'b1;
                        pc_d    = j_tgt;
                        state_d = FETCH;
                    end
`endif
                    OP_LW, OP_SW: state_d = MEM;
                    default:      state_d = WB;
                endcase
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_we   = (opcode == OP_SW);
                mem_addr = alu_q[ADDR_W-1:0];
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire  = 1'b1;
                        pc_d    = pc4;
                        state_d = FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                retire  = 1'b1;
                pc_d    = pc4;
                state_d = FETCH;
                if (opcode == OP_R) begin
                    if (rd != 5'd0) rf_d[rd] = alu_q;
                end else if (rt != 5'd0) begin
                    rf_d[rt] = mdr_q;
                end
            end
            default: ;
        endcase

        // Timeout overrides whatever the state wanted; the request drops next cycle.
        if (mem_req && !mem_ready) begin
            wait_d = wait_q + 8'd1;
            if (wait_q == WAIT_LAST) begin
                wait_d  = '0;
                state_d = HALT;
                err_d   = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            wait_q  <= '0;
            err_q   <= 2'b00;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            run_q   <= run_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign pc_out   = pc_q;
    assign halted   = (state_q == HALT);
    assign err_code = err_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small memory model with per-address wait injection and store log.
module tb_multicycle_core;

    localparam int TO = 16;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    multicycle_core #(.ADDR_W(32), .RESET_PC(32'h0), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc_out(pc_out), .retire(retire),
        .halted(halted), .err_code(err_code)
    );

    // Memory model: program/preload image plus a store overlay cleared by reset.
    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    logic        dval [256];
    logic [31:0] st_addr_q [$];
    logic [31:0] st_data_q [$];
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_len = 0;
    int          wait_seen = 0;
    int          cyc = 0;
    int          ret_cyc [$];
    logic [31:0] ret_pc [$];
    int          n_vec = 0;
    int          n_err = 0;

    assign mem_rdata = dval[mem_addr[9:2]] ? dmem[mem_addr[9:2]] : imem[mem_addr[9:2]];
    assign mem_ready = !(mem_req && (mem_addr == stall_addr) && (wait_seen < stall_len));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) dval[i] <= 1'b0;
            wait_seen <= 0;
        end else begin
            if (mem_req && mem_we && mem_ready) begin
                dmem[mem_addr[9:2]] <= mem_wdata;
                dval[mem_addr[9:2]] <= 1'b1;
                st_addr_q.push_back(mem_addr);
                st_data_q.push_back(mem_wdata);
            end
            if (mem_req && (mem_addr == stall_addr) && !mem_ready) wait_seen <= wait_seen + 1;
            else wait_seen <= 0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && retire) begin
            ret_cyc.push_back(cyc);
            ret_pc.push_back(pc_out);
        end
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh,
                                          input logic [5:0] fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic hold_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        stall_addr = 32'hFFFF_FFFF;
        stall_len  = 0;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_retires(input int n, input int budget);
        int k = 0;
        while (ret_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_halt(input int budget);
        int k = 0;
        while (halted !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_addr(input logic [31:0] a, input int budget, output bit found);
        int k = 0;
        found = 1'b0;
        while (k < budget && !found) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_addr === a) found = 1'b1;
            k++;
        end
    endtask

    task automatic test_reset();
        hold_reset();
        imem[0]    = enc_i(OP_BEQ, 0, 0, 16'hFFFF);
        stall_addr = 32'h0;
        stall_len  = 1000;
        #1;
        n_vec++; if ({mem_req, mem_we, retire, halted, err_code} !== 6'b0) begin n_err++;
            $display("FAIL reset_outputs: req/we/ret/halt/err=%b want 000000", {mem_req, mem_we, retire, halted, err_code}); end
        n_vec++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", pc_out); end
        release_reset();
        repeat (4) @(negedge clk);
        n_vec++; if ({mem_req, mem_ready} !== 2'b10) begin n_err++;
            $display("FAIL stalled_fetch: req/ready=%b want 10", {mem_req, mem_ready}); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({mem_req, halted, err_code} !== 4'b0) begin n_err++;
            $display("FAIL midreq_reset: req/halt/err=%b want 0000", {mem_req, halted, err_code}); end
        stall_len = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL req_at_release: got %b want 0", mem_req); end
        @(posedge clk);
        #1;
        n_vec++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0}) begin n_err++;
            $display("FAIL first_fetch: req=%b we=%b addr=%h want 1 0 0", mem_req, mem_we, mem_addr); end
    endtask

    task automatic test_alu_add();
        int r, s;
        hold_reset();
        imem[0]  = enc_i(OP_LW, 0, 1, 16'h80);
        imem[1]  = enc_i(OP_LW, 0, 2, 16'h84);
        imem[2]  = enc_r(1, 2, 3, 0, 6'b100000);
        imem[3]  = enc_i(OP_SW, 0, 3, 16'h180);
        imem[4]  = enc_i(OP_BEQ, 1, 1, 16'hFFFF);
        imem[32] = 32'd5;
        imem[33] = 32'd7;
        r = ret_cyc.size();
        s = st_addr_q.size();
        release_reset();
        wait_retires(r + 7, 300);
        n_vec++; if (ret_cyc.size() < r + 7) begin n_err++;
            $display("FAIL add_retires: got %0d want %0d", ret_cyc.size() - r, 7); end
        else begin
            n_vec++; if (ret_cyc[r+1] - ret_cyc[r] !== 5) begin n_err++;
                $display("FAIL lw_cycles: got %0d want 5", ret_cyc[r+1] - ret_cyc[r]); end
            n_vec++; if (ret_cyc[r+2] - ret_cyc[r+1] !== 4) begin n_err++;
                $display("FAIL add_cycles: got %0d want 4", ret_cyc[r+2] - ret_cyc[r+1]); end
            n_vec++; if (ret_pc[r+2] !== 32'h8 || ret_pc[r+3] !== 32'hC) begin n_err++;
                $display("FAIL add_pc: got %h,%h want 8,c", ret_pc[r+2], ret_pc[r+3]); end
            n_vec++; if (ret_cyc[r+4] - ret_cyc[r+3] !== 3) begin n_err++;
                $display("FAIL beq_cycles: got %0d want 3", ret_cyc[r+4] - ret_cyc[r+3]); end
            n_vec++; if (ret_pc[r+4] !== 32'h10 || ret_pc[r+5] !== 32'h10 || ret_pc[r+6] !== 32'h10) begin n_err++;
                $display("FAIL beq_loop_pc: got %h,%h,%h want 10", ret_pc[r+4], ret_pc[r+5], ret_pc[r+6]); end
        end
        n_vec++; if (st_addr_q.size() < s + 1) begin n_err++;
            $display("FAIL add_store_count: got %0d want 1", st_addr_q.size() - s); end
        else begin
            n_vec++; if (st_addr_q[s] !== 32'h180 || st_data_q[s] !== 32'd12) begin n_err++;
                $display("FAIL add_result: got %h@%h want 0000000c@00000180", st_data_q[s], st_addr_q[s]); end
        end
    endtask

    task automatic test_load_store();
        int r, s;
        logic [31:0] ea [7];
        logic [31:0] ed [7];
        hold_reset();
        imem[0]  = enc_i(OP_LW, 0, 1, 16'h80);
        imem[1]  = enc_i(OP_LW, 0, 2, 16'h84);
        imem[2]  = enc_i(OP_SW, 0, 2, 16'h8);
        imem[3]  = enc_i(OP_LW, 0, 4, 16'h8);
        imem[4]  = enc_i(OP_BEQ, 1, 2, 16'h5);
        imem[5]  = enc_i(OP_SW, 0, 4, 16'h180);
        imem[6]  = enc_r(1, 2, 5, 0, 6'b100010);
        imem[7]  = enc_i(OP_SW, 0, 5, 16'h184);
        imem[8]  = enc_r(0, 5, 6, 4, 6'b000010);
        imem[9]  = enc_i(OP_SW, 0, 6, 16'h188);
        imem[10] = enc_r(5, 2, 7, 0, 6'b100100);
        imem[11] = enc_i(OP_SW, 0, 7, 16'h18C);
        imem[12] = enc_r(7, 1, 8, 0, 6'b100101);
        imem[13] = enc_i(OP_SW, 0, 8, 16'h190);
        imem[14] = enc_r(1, 2, 0, 0, 6'b100000);
        imem[15] = enc_i(OP_SW, 0, 0, 16'h194);
        imem[16] = enc_i(OP_BEQ, 0, 0, 16'hFFFF);
        imem[32] = 32'd5;
        imem[33] = 32'd7;
        ea = '{32'h8, 32'h180, 32'h184, 32'h188, 32'h18C, 32'h190, 32'h194};
        ed = '{32'd7, 32'd7, 32'hFFFF_FFFE, 32'h0FFF_FFFF, 32'd6, 32'd7, 32'd0};
        r = ret_cyc.size();
        s = st_addr_q.size();
        release_reset();
        wait_retires(r + 17, 400);
        n_vec++; if (ret_cyc.size() < r + 17) begin n_err++;
            $display("FAIL ls_retires: got %0d want 17", ret_cyc.size() - r); end
        else begin
            n_vec++; if (ret_cyc[r+2] - ret_cyc[r+1] !== 4) begin n_err++;
                $display("FAIL sw_cycles: got %0d want 4", ret_cyc[r+2] - ret_cyc[r+1]); end
            n_vec++; if (ret_cyc[r+3] - ret_cyc[r+2] !== 5) begin n_err++;
                $display("FAIL lw_after_sw_cycles: got %0d want 5", ret_cyc[r+3] - ret_cyc[r+2]); end
            n_vec++; if (ret_pc[r+4] !== 32'h10 || ret_pc[r+5] !== 32'h14) begin n_err++;
                $display("FAIL beq_not_taken: got %h,%h want 10,14", ret_pc[r+4], ret_pc[r+5]); end
        end
        n_vec++; if (st_addr_q.size() < s + 7) begin n_err++;
            $display("FAIL ls_store_count: got %0d want 7", st_addr_q.size() - s); end
        else begin
            for (int i = 0; i < 7; i++) begin
                n_vec++; if (st_addr_q[s+i] !== ea[i] || st_data_q[s+i] !== ed[i]) begin n_err++;
                    $display("FAIL ls_store%0d: got %h@%h want %h@%h", i, st_data_q[s+i], st_addr_q[s+i], ed[i], ea[i]); end
            end
        end
    endtask

    task automatic test_mem_wait();
        int s;
        bit found;
        hold_reset();
        imem[0]    = enc_i(OP_LW, 0, 1, 16'h80);
        imem[1]    = enc_i(OP_SW, 0, 1, 16'h180);
        imem[2]    = enc_i(OP_BEQ, 0, 0, 16'hFFFF);
        imem[32]   = 32'd5;
        stall_addr = 32'h80;
        stall_len  = 3;
        s = st_addr_q.size();
        release_reset();
        wait_addr(32'h80, 50, found);
        n_vec++; if (!found) begin n_err++; $display("FAIL wait_lw_req: got none want addr 80"); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if ({mem_req, mem_ready, mem_we, mem_addr} !== {1'b1, 1'b0, 1'b0, 32'h80}) begin n_err++;
                $display("FAIL wait_stable%0d: req=%b rdy=%b we=%b addr=%h want 1 0 0 80", i, mem_req, mem_ready, mem_we, mem_addr); end
            @(negedge clk);
        end
        n_vec++; if ({mem_req, mem_ready, retire} !== 3'b110) begin n_err++;
            $display("FAIL wait_accept: req/rdy/ret=%b want 110", {mem_req, mem_ready, retire}); end
        @(negedge clk);
        n_vec++; if ({retire, pc_out} !== {1'b1, 32'h0}) begin n_err++;
            $display("FAIL wait_retire: ret=%b pc=%h want 1 0", retire, pc_out); end
        repeat (8) @(negedge clk);
        n_vec++; if (st_addr_q.size() < s + 1) begin n_err++;
            $display("FAIL wait_store_count: got %0d want 1", st_addr_q.size() - s); end
        else begin
            n_vec++; if (st_data_q[s] !== 32'd5) begin n_err++;
                $display("FAIL wait_load_data: got %h want 5", st_data_q[s]); end
        end
    endtask

    task automatic test_timeout();
        int r;
        bit found;
        hold_reset();
        imem[0]    = enc_i(OP_LW, 0, 1, 16'h80);
        imem[1]    = enc_i(OP_BEQ, 0, 0, 16'hFFFF);
        stall_addr = 32'h80;
        stall_len  = TO - 1;
        release_reset();
        wait_addr(32'h80, 50, found);
        n_vec++; if (!found) begin n_err++; $display("FAIL to_req_a: got none want addr 80"); end
        repeat (TO - 1) @(negedge clk);
        n_vec++; if ({halted, mem_ready} !== 2'b01) begin n_err++;
            $display("FAIL to_boundary_accept: halt/rdy=%b want 01", {halted, mem_ready}); end
        @(negedge clk);
        n_vec++; if (retire !== 1'b1) begin n_err++; $display("FAIL to_boundary_retire: got %b want 1", retire); end

        hold_reset();
        imem[0]    = enc_i(OP_LW, 0, 1, 16'h80);
        stall_addr = 32'h80;
        stall_len  = TO;
        release_reset();
        wait_addr(32'h80, 50, found);
        n_vec++; if (!found) begin n_err++; $display("FAIL to_req_b: got none want addr 80"); end
        repeat (TO - 1) @(negedge clk);
        n_vec++; if ({halted, mem_req} !== 2'b01) begin n_err++;
            $display("FAIL to_last_wait: halt/req=%b want 01", {halted, mem_req}); end
        @(negedge clk);
        n_vec++; if ({halted, mem_req, retire, err_code} !== 5'b10010) begin n_err++;
            $display("FAIL to_halt: halt/req/ret/err=%b want 10010", {halted, mem_req, retire, err_code}); end
        r = ret_cyc.size();
        repeat (6) @(negedge clk);
        n_vec++; if ({halted, mem_req, err_code, pc_out} !== {1'b1, 1'b0, 2'b10, 32'h0} || ret_cyc.size() != r) begin n_err++;
            $display("FAIL to_sticky: halt=%b req=%b err=%b pc=%h extra_ret=%0d want 1 0 10 0 0",
                     halted, mem_req, err_code, pc_out, ret_cyc.size() - r); end
    endtask

    task automatic test_illegal();
        int r;
        hold_reset();
        imem[0] = 32'hFC00_0000;
        r = ret_cyc.size();
        release_reset();
        wait_halt(30);
        repeat (2) @(negedge clk);
        n_vec++; if ({halted, err_code, mem_req} !== 4'b1010) begin n_err++;
            $display("FAIL ill_op: halt/err/req=%b want 1010", {halted, err_code, mem_req}); end
        n_vec++; if (ret_cyc.size() != r || pc_out !== 32'h0) begin n_err++;
            $display("FAIL ill_op_noretire: retires=%0d pc=%h want 0 0", ret_cyc.size() - r, pc_out); end

        hold_reset();
        imem[0]  = enc_i(OP_LW, 0, 1, 16'h80);
        imem[1]  = enc_r(1, 1, 2, 0, 6'b000000);
        imem[32] = 32'd9;
        r = ret_cyc.size();
        release_reset();
        wait_halt(40);
        repeat (2) @(negedge clk);
        n_vec++; if ({halted, err_code} !== 3'b101 || ret_cyc.size() != r + 1 || pc_out !== 32'h4) begin n_err++;
            $display("FAIL ill_funct: halt/err=%b retires=%0d pc=%h want 101 1 4",
                     {halted, err_code}, ret_cyc.size() - r, pc_out); end

        hold_reset();
        #1;
        n_vec++; if ({halted, err_code, pc_out} !== {1'b0, 2'b00, 32'h0}) begin n_err++;
            $display("FAIL ill_reset_clear: halt=%b err=%b pc=%h want 0 00 0", halted, err_code, pc_out); end
        imem[0] = enc_i(OP_BEQ, 0, 0, 16'hFFFF);
        r = ret_cyc.size();
        release_reset();
        wait_retires(r + 1, 20);
        n_vec++; if (ret_cyc.size() < r + 1 || halted !== 1'b0) begin n_err++;
            $display("FAIL ill_resume: retires=%0d halt=%b want >=1 0", ret_cyc.size() - r, halted); end
    endtask

    task automatic test_jump();
        int r;
        hold_reset();
        imem[0]  = {6'b000010, 26'h40};
        imem[64] = enc_i(OP_BEQ, 0, 0, 16'hFFFF);
        r = ret_cyc.size();
        release_reset();
`ifdef MULTICYCLE_CORE_JUMP_EN
        wait_retires(r + 3, 40);
        n_vec++; if (ret_cyc.size() < r + 3) begin n_err++;
            $display("FAIL jump_retires: got %0d want 3", ret_cyc.size() - r); end
        else begin
            n_vec++; if (ret_pc[r] !== 32'h0 || ret_pc[r+1] !== 32'h100 || ret_pc[r+2] !== 32'h100) begin n_err++;
                $display("FAIL jump_target: got %h,%h,%h want 0,100,100", ret_pc[r], ret_pc[r+1], ret_pc[r+2]); end
        end
`else
        wait_halt(30);
        repeat (2) @(negedge clk);
        n_vec++; if ({halted, err_code} !== 3'b101 || ret_cyc.size() != r) begin n_err++;
            $display("FAIL jump_illegal: halt/err=%b retires=%0d want 101 0", {halted, err_code}, ret_cyc.size() - r); end
`endif
    endtask

    initial begin
        test_reset();
        test_alu_add();
        test_load_store();
        test_mem_wait();
        test_timeout();
        test_illegal();
        test_jump();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
